// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the raster timing generator.
package video_timing_pkg;

  localparam int RGB_W  = 24;
  localparam int SLOT_W = 3;

  typedef logic [RGB_W-1:0] rgb_t;

  // Counter width needed to hold 0..n-1.
  function automatic int total_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register with synchronous clear; depth 0 collapses to a wire.
module video_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = i_clk ^ i_clear;
      assign o_q      = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Shift one stage per cycle; clear flushes everything in flight.
      always_ff @(posedge i_clk) begin
        if (i_clear) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: fetch-side h/v counters issue pixel requests
// PIX_LATENCY cycles ahead of display; de/hs/vs are delayed to line up with
// the returned pixel and registered together with it.
// Optional build macro: VIDEO_TIMING_SCALER_SLOT_EN (emit latched slot index
// on the first blank cycle after each active run).
//
// Fetch contract: px_req/px_x/px_y are combinational from the counters.
// There is no back-pressure; px_data must be valid exactly PIX_LATENCY
// cycles after px_req (same cycle when PIX_LATENCY is 0).
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE    = 320,
  parameter int H_FP        = 8,
  parameter int H_BP        = 40,
  parameter int V_ACTIVE    = 240,
  parameter int V_FP        = 2,
  parameter int V_BP        = 16,
  parameter int PIX_LATENCY = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic [SLOT_W-1:0]                         slot,
  output logic                                      px_req,
  output logic [total_w(H_ACTIVE+H_FP+H_BP)-1:0]    px_x,
  output logic [total_w(V_ACTIVE+V_FP+V_BP)-1:0]    px_y,
  input  rgb_t                                      px_data,
  output logic                                      frame_start,
  output rgb_t                                      video_rgb,
  output logic                                      video_de,
  output logic                                      video_hs,
  output logic                                      video_vs,
  output logic                                      video_skip
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_BP;
  localparam int HW      = total_w(H_TOTAL);
  localparam int VW      = total_w(V_TOTAL);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  int            w_h_i;
  int            w_v_i;
  logic          w_run;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_de_e;
  logic          w_hs_e;
  logic          w_vs_e;
  logic [2:0]    w_flags_in;
  logic [2:0]    w_flags_d;
  logic          w_de_d;
  logic          w_hs_d;
  logic          w_vs_d;
  rgb_t          w_blank_rgb;

  logic          r_de;
  logic          r_hs;
  logic          r_vs;
  rgb_t          r_rgb;

  // Compare at full integer width so no total is ever truncated.
  assign w_h_i    = int'(r_h);
  assign w_v_i    = int'(r_v);
  assign w_run    = enable && !reset;
  assign w_h_last = (w_h_i == H_TOTAL - 1);
  assign w_v_last = (w_v_i == V_TOTAL - 1);

  // Fetch position: advance while running, park at frame origin otherwise.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // Fetch-side raster decode.
  assign w_de_e = (w_h_i < H_ACTIVE) && (w_v_i < V_ACTIVE);
  assign w_hs_e = (w_h_i == H_ACTIVE + H_FP);
  assign w_vs_e = (w_h_i == 0) && (w_v_i == V_ACTIVE + V_FP);

  assign px_req      = w_de_e && w_run;
  assign px_x        = r_h;
  assign px_y        = r_v;
  assign frame_start = w_run && (w_h_i == 0) && (w_v_i == 0);

  // Zeros enter the pipe while stopped so in-flight flags drain cleanly.
  assign w_flags_in = {w_de_e, w_hs_e, w_vs_e} & {3{w_run}};

  video_delay_line #(
    .WIDTH (3),
    .DEPTH (PIX_LATENCY)
  ) u_flag_delay (
    .i_clk   (clk),
    .i_clear (reset),
    .i_d     (w_flags_in),
    .o_q     (w_flags_d)
  );

  assign {w_de_d, w_hs_d, w_vs_d} = w_flags_d;

`ifdef VIDEO_TIMING_SCALER_SLOT_EN
  logic [SLOT_W-1:0] r_slot;

  // Capture the scaler slot once per frame at the origin fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot <= '0;
    end else if (frame_start) begin
      r_slot <= slot;
    end
  end

  // The output cycle right after de falls carries the slot index.
  assign w_blank_rgb = r_de ? rgb_t'({{(RGB_W-SLOT_W){1'b0}}, r_slot}) : '0;
`else
  logic w_unused_slot;
  assign w_unused_slot = ^slot;
  assign w_blank_rgb   = '0;
`endif

  // Output register: delayed flags and returned pixel sampled together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_de  <= 1'b0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_de  <= w_de_d;
      r_hs  <= w_hs_d;
      r_vs  <= w_vs_d;
      r_rgb <= w_de_d ? px_data : w_blank_rgb;
    end
  end

  assign video_de   = r_de;
  assign video_hs   = r_hs;
  assign video_vs   = r_vs;
  assign video_rgb  = r_rgb;
  assign video_skip = 1'b0;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small raster (8x5, 40-cycle frame), one
// instance at PIX_LATENCY=2 and one at PIX_LATENCY=0 sharing stimulus.
// Expected outputs come from a position-based raster model plus a per-cycle
// history of what each fetch should produce.
module tb_video_timing_gen;

  localparam int HA = 4, HF = 2, HB = 2;
  localparam int VA = 3, VF = 1, VB = 1;
  localparam int HT = HA + HF + HB;
  localparam int VT = VA + VF + VB;
  localparam int FRAME = HT * VT;
  localparam logic [2:0] SLOT_VAL = 3'd5;
`ifdef VIDEO_TIMING_SCALER_SLOT_EN
  localparam bit SLOT_EN = 1'b1;
`else
  localparam bit SLOT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] pix;
  } fetch_t;

  // clock / reset
  logic clk;
  logic reset;
  logic enable;
  logic [2:0] slot;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // latency-2 instance
  logic        px_req, frame_start, video_de, video_hs, video_vs, video_skip;
  logic [2:0]  px_x, px_y;
  logic [23:0] px_data, video_rgb;

  // latency-0 instance
  logic        px_req0, frame_start0, video_de0, video_hs0, video_vs0, video_skip0;
  logic [2:0]  px_x0, px_y0;
  logic [23:0] px_data0, video_rgb0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF), .V_BP(VB), .PIX_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .slot(slot),
    .px_req(px_req), .px_x(px_x), .px_y(px_y), .px_data(px_data),
    .frame_start(frame_start), .video_rgb(video_rgb), .video_de(video_de),
    .video_hs(video_hs), .video_vs(video_vs), .video_skip(video_skip)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF), .V_BP(VB), .PIX_LATENCY(0)
  ) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .slot(slot),
    .px_req(px_req0), .px_x(px_x0), .px_y(px_y0), .px_data(px_data0),
    .frame_start(frame_start0), .video_rgb(video_rgb0), .video_de(video_de0),
    .video_hs(video_hs0), .video_vs(video_vs0), .video_skip(video_skip0)
  );

  // Zero-latency pixel source answers in the same cycle.
  assign px_data0 = {8'h00, 5'b0, px_y0, 5'b0, px_x0};

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pos      = 0;
  int last_rst = -1;
  fetch_t hist[$];
  logic [24:0] pd_q[$];

  logic        e_req, e_fs;
  int          e_x, e_y;
  fetch_t      e2, e0;
  logic [23:0] e2_rgb, e0_rgb;

  // What the output register shows at cycle k for a given latency.
  function automatic fetch_t exp_at(input int k, input int lat);
    fetch_t z;
    int src;
    z = '0;
    src = k - lat - 1;
    if (src < 0) return z;
    if (last_rst >= src) return z;
    return hist[src];
  endfunction

  function automatic logic [23:0] exp_rgb(input int k, input int lat);
    fetch_t cur;
    fetch_t prv;
    cur = exp_at(k, lat);
    prv = exp_at(k - 1, lat);
    if (cur.de) return cur.pix;
    if (SLOT_EN && prv.de && (last_rst != k - 1)) return {21'b0, SLOT_VAL};
    return 24'h0;
  endfunction

  // driver: one clock cycle of stimulus plus the model update
  task automatic step(input logic en, input logic rst);
    fetch_t f;
    logic [24:0] pd;
    int h, v;
    @(negedge clk);
    enable = en;
    reset  = rst;
    pd = pd_q.pop_front();
    px_data = pd[24] ? pd[23:0] : 24'($urandom);
    #1;
    pd_q.push_back({px_req, 8'h00, 5'b0, px_y, 5'b0, px_x});
    h = pos % HT;
    v = pos / HT;
    f = '0;
    if (en && !rst) begin
      f.de = (h < HA) && (v < VA);
      f.hs = (h == HA + HF);
      f.vs = (h == 0) && (v == VA + VF);
      if (f.de) f.pix = {8'h00, 8'(v), 8'(h)};
    end
    hist.push_back(f);
    e_req  = f.de;
    e_x    = h;
    e_y    = v;
    e_fs   = en && !rst && (pos == 0);
    e2     = exp_at(cyc, 2);
    e0     = exp_at(cyc, 0);
    e2_rgb = exp_rgb(cyc, 2);
    e0_rgb = exp_rgb(cyc, 0);
    if (rst) last_rst = cyc;
    pos = (en && !rst) ? (pos + 1) % FRAME : 0;
    cyc++;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1);
    n_checks++; if (video_de !== 1'b0) begin n_fail++; $display("FAIL reset_de got %b want 0", video_de); end
    n_checks++; if (video_hs !== 1'b0 || video_vs !== 1'b0) begin n_fail++; $display("FAIL reset_sync got hs=%b vs=%b want 0", video_hs, video_vs); end
    n_checks++; if (video_rgb !== 24'h0) begin n_fail++; $display("FAIL reset_rgb got %h want 0", video_rgb); end
    n_checks++; if (px_req !== 1'b0 || frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fetch got req=%b fs=%b want 0", px_req, frame_start); end
    n_checks++; if (video_skip !== 1'b0) begin n_fail++; $display("FAIL reset_skip got %b want 0", video_skip); end
    step(1'b1, 1'b0);
    n_checks++; if (frame_start !== 1'b1 || px_req !== 1'b1) begin n_fail++; $display("FAIL first_fetch got fs=%b req=%b want 1", frame_start, px_req); end
    n_checks++; if (px_x !== 3'd0 || px_y !== 3'd0) begin n_fail++; $display("FAIL first_xy got %0d,%0d want 0,0", px_x, px_y); end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 80; i++) begin
      step(1'b1, 1'b0);
      n_checks++; if (px_req !== e_req) begin n_fail++; $display("FAIL run_req cyc=%0d got %b want %b", cyc, px_req, e_req); end
      n_checks++; if (frame_start !== e_fs) begin n_fail++; $display("FAIL run_fs cyc=%0d got %b want %b", cyc, frame_start, e_fs); end
      if (e_req) begin
        n_checks++; if (px_x !== 3'(e_x) || px_y !== 3'(e_y)) begin n_fail++; $display("FAIL run_xy cyc=%0d got %0d,%0d want %0d,%0d", cyc, px_x, px_y, e_x, e_y); end
      end
      n_checks++; if (video_de !== e2.de) begin n_fail++; $display("FAIL run_de cyc=%0d got %b want %b", cyc, video_de, e2.de); end
      n_checks++; if (video_rgb !== e2_rgb) begin n_fail++; $display("FAIL run_rgb cyc=%0d got %h want %h", cyc, video_rgb, e2_rgb); end
      n_checks++; if (video_hs !== e2.hs || video_vs !== e2.vs) begin n_fail++; $display("FAIL run_sync cyc=%0d got hs=%b vs=%b want hs=%b vs=%b", cyc, video_hs, video_vs, e2.hs, e2.vs); end
      n_checks++; if (video_de0 !== e0.de || video_rgb0 !== e0_rgb) begin n_fail++; $display("FAIL run_lat0 cyc=%0d got de=%b rgb=%h want de=%b rgb=%h", cyc, video_de0, video_rgb0, e0.de, e0_rgb); end
    end
  endtask

  task automatic test_sync();
    int n_hs = 0;
    int n_vs = 0;
    for (int i = 0; i < 80; i++) begin
      step(1'b1, 1'b0);
      n_hs += int'(video_hs);
      n_vs += int'(video_vs);
      n_checks++; if (video_hs !== e2.hs || video_vs !== e2.vs) begin n_fail++; $display("FAIL sync_place cyc=%0d got hs=%b vs=%b want hs=%b vs=%b", cyc, video_hs, video_vs, e2.hs, e2.vs); end
      n_checks++; if ((video_hs & video_vs) !== 1'b0) begin n_fail++; $display("FAIL sync_overlap cyc=%0d got both high want exclusive", cyc); end
    end
    n_checks++; if (n_hs != 10) begin n_fail++; $display("FAIL sync_hs_count got %0d want 10", n_hs); end
    n_checks++; if (n_vs != 2) begin n_fail++; $display("FAIL sync_vs_count got %0d want 2", n_vs); end
  endtask

  task automatic test_blank_rgb();
    int n_slot = 0;
    for (int i = 0; i < 80; i++) begin
      step(1'b1, 1'b0);
      if (!video_de && video_rgb == 24'h000005) n_slot++;
      if (!e2.de) begin
        n_checks++; if (video_rgb !== e2_rgb) begin n_fail++; $display("FAIL blank_rgb cyc=%0d got %h want %h", cyc, video_rgb, e2_rgb); end
      end
    end
    n_checks++; if (n_slot != (SLOT_EN ? 6 : 0)) begin n_fail++; $display("FAIL blank_slot_count got %0d want %0d", n_slot, SLOT_EN ? 6 : 0); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2 * FRAME && pos != HT + 2; i++) step(1'b1, 1'b0);
    n_checks++; if (pos != HT + 2) begin n_fail++; $display("FAIL rmid_reach got pos %0d want %0d", pos, HT + 2); end
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    n_checks++; if (video_de !== 1'b0 || video_hs !== 1'b0 || video_vs !== 1'b0 || video_rgb !== 24'h0) begin
      n_fail++; $display("FAIL rmid_outs got de=%b hs=%b vs=%b rgb=%h want 0", video_de, video_hs, video_vs, video_rgb);
    end
    n_checks++; if (video_de0 !== 1'b0 || video_rgb0 !== 24'h0) begin n_fail++; $display("FAIL rmid_lat0 got de=%b rgb=%h want 0", video_de0, video_rgb0); end
    n_checks++; if (frame_start !== 1'b1 || px_req !== 1'b1) begin n_fail++; $display("FAIL rmid_restart got fs=%b req=%b want 1", frame_start, px_req); end
    n_checks++; if (px_x !== 3'd0 || px_y !== 3'd0) begin n_fail++; $display("FAIL rmid_xy got %0d,%0d want 0,0", px_x, px_y); end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      n_checks++; if (video_de !== e2.de || video_rgb !== e2_rgb) begin n_fail++; $display("FAIL rmid_after cyc=%0d got de=%b rgb=%h want de=%b rgb=%h", cyc, video_de, video_rgb, e2.de, e2_rgb); end
    end
  endtask

  task automatic test_enable_gap();
    int n_de = 0;
    int n_hs = 0;
    repeat (4) step(1'b1, 1'b0);
    for (int i = 0; i < 2 * FRAME && pos != HT + 1; i++) step(1'b1, 1'b0);
    n_checks++; if (pos != HT + 1) begin n_fail++; $display("FAIL gap_reach got pos %0d want %0d", pos, HT + 1); end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      n_de += int'(video_de);
      n_hs += int'(video_hs);
      n_checks++; if (px_req !== 1'b0) begin n_fail++; $display("FAIL gap_req cyc=%0d got %b want 0", cyc, px_req); end
      n_checks++; if (video_de !== e2.de || video_hs !== e2.hs || video_rgb !== e2_rgb) begin
        n_fail++; $display("FAIL gap_drain cyc=%0d got de=%b hs=%b rgb=%h want de=%b hs=%b rgb=%h", cyc, video_de, video_hs, video_rgb, e2.de, e2.hs, e2_rgb);
      end
    end
    n_checks++; if (n_de != 1 || n_hs != 1) begin n_fail++; $display("FAIL gap_counts got de=%0d hs=%0d want 1,1", n_de, n_hs); end
    step(1'b1, 1'b0);
    n_checks++; if (frame_start !== 1'b1 || px_req !== 1'b1 || px_y !== 3'd0 || px_x !== 3'd0) begin
      n_fail++; $display("FAIL gap_restart got fs=%b req=%b x=%0d y=%0d want 1,1,0,0", frame_start, px_req, px_x, px_y);
    end
  endtask

  task automatic test_latency0();
    repeat (4) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_checks++; if (px_req0 !== 1'b1 || video_de0 !== 1'b0) begin n_fail++; $display("FAIL lat0_rise got req=%b de=%b want 1,0", px_req0, video_de0); end
    step(1'b1, 1'b0);
    n_checks++; if (video_de0 !== 1'b1) begin n_fail++; $display("FAIL lat0_de got %b want 1", video_de0); end
    n_checks++; if (video_rgb0 !== 24'h0) begin n_fail++; $display("FAIL lat0_rgb got %h want 000000", video_rgb0); end
    n_checks++; if (video_de !== 1'b0) begin n_fail++; $display("FAIL lat2_early got %b want 0", video_de); end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    n_checks++; if (video_de !== 1'b1) begin n_fail++; $display("FAIL lat2_de got %b want 1", video_de); end
  endtask

  task automatic test_random();
    logic en, rst;
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 59) == 0);
      step(en, rst);
      n_checks++; if (px_req !== e_req || frame_start !== e_fs) begin n_fail++; $display("FAIL rnd_fetch cyc=%0d got req=%b fs=%b want req=%b fs=%b", cyc, px_req, frame_start, e_req, e_fs); end
      if (e_req) begin
        n_checks++; if (px_x !== 3'(e_x) || px_y !== 3'(e_y)) begin n_fail++; $display("FAIL rnd_xy cyc=%0d got %0d,%0d want %0d,%0d", cyc, px_x, px_y, e_x, e_y); end
      end
      n_checks++; if (video_de !== e2.de || video_rgb !== e2_rgb) begin n_fail++; $display("FAIL rnd_out cyc=%0d got de=%b rgb=%h want de=%b rgb=%h", cyc, video_de, video_rgb, e2.de, e2_rgb); end
      n_checks++; if (video_hs !== e2.hs || video_vs !== e2.vs) begin n_fail++; $display("FAIL rnd_sync cyc=%0d got hs=%b vs=%b want hs=%b vs=%b", cyc, video_hs, video_vs, e2.hs, e2.vs); end
      n_checks++; if (video_de0 !== e0.de || video_rgb0 !== e0_rgb || video_hs0 !== e0.hs || video_vs0 !== e0.vs) begin
        n_fail++; $display("FAIL rnd_lat0 cyc=%0d got de=%b rgb=%h want de=%b rgb=%h", cyc, video_de0, video_rgb0, e0.de, e0_rgb);
      end
      n_checks++; if (video_skip !== 1'b0 || video_skip0 !== 1'b0) begin n_fail++; $display("FAIL rnd_skip cyc=%0d got %b,%b want 0", cyc, video_skip, video_skip0); end
    end
  endtask

  // sequence + final report
  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    slot    = SLOT_VAL;
    px_data = 24'h0;
    pd_q.push_back(25'h0);
    pd_q.push_back(25'h0);
    repeat (2) @(posedge clk);
    test_reset();
    test_free_run();
    test_sync();
    test_blank_rgb();
    test_reset_mid();
    test_enable_gap();
    test_latency0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
